// File: rtl/mlp_pkg.sv
// Shared types and defaults for the MLP layer sequencer.
package mlp_pkg;
  localparam int MAX_LAYERS_D    = 8;
  localparam int LAYER_W_D       = 3;
  localparam int NEURON_W_D      = 8;
  localparam int WEIGHT_ADDR_W_D = 16;
  localparam int MEM_LAT_D       = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  typedef logic [LAYER_W_D-1:0]  layer_idx_t;
  typedef logic [NEURON_W_D-1:0] neuron_idx_t;

  // {layer, index}; caller truncates to its own address width.
  function automatic logic [31:0] neuron_addr(
    input logic [31:0] layer,
    input logic [31:0] idx,
    input int unsigned nw
  );
    return (layer << nw) | idx;
  endfunction
endpackage

// File: rtl/mlp_lat_pipe.sv
// Fixed-depth delay line for read-side control bits.
module mlp_lat_pipe #(
  parameter int LAT = 1,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] pipe_q [LAT];
  logic [W-1:0] pipe_d [LAT];

  always_comb begin
    pipe_d[0] = d;
    for (int i = 1; i < LAT; i++)
      pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++)
        pipe_q[i] <= '0;
    end else begin
      for (int i = 0; i < LAT; i++)
        pipe_q[i] <= pipe_d[i];
    end
  end

  assign q = pipe_q[LAT-1];
endmodule

// File: rtl/mlp_sequencer.sv
// Table-driven layer sequencer: issues MAC reads,
// realigns accumulate enables and writes each neuron.
module mlp_sequencer
  import mlp_pkg::*;
#(
  parameter int MAX_LAYERS    = MAX_LAYERS_D,
  parameter int LAYER_W       = LAYER_W_D,
  parameter int NEURON_W      = NEURON_W_D,
  parameter int WEIGHT_ADDR_W = WEIGHT_ADDR_W_D,
  parameter int MEM_LAT       = MEM_LAT_D
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_we,
  input  logic [LAYER_W-1:0]          cfg_layer,
  input  logic [NEURON_W-1:0]         cfg_count,
  input  logic [LAYER_W:0]            cfg_num_layers,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic                        rd_en,
  output logic [LAYER_W+NEURON_W-1:0] in_neuron_addr,
  output logic [WEIGHT_ADDR_W-1:0]    wt_addr,
  output logic                        acc_en,
  output logic                        acc_clr,
  output logic                        wr_en,
  output logic [LAYER_W+NEURON_W-1:0] out_neuron_addr
);
  localparam int AW = LAYER_W + NEURON_W;
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_e                 state_q, state_d;
  logic [NEURON_W-1:0]    tbl_q [MAX_LAYERS];
  logic [NEURON_W-1:0]    tbl_d [MAX_LAYERS];
  logic [LAYER_W:0]       nl_q, nl_d;
  logic [LAYER_W-1:0]     layer_q, layer_d;
  logic [LAYER_W-1:0]     layer_nx;
  logic [NEURON_W-1:0]    in_idx_q, in_idx_d;
  logic [NEURON_W-1:0]    out_idx_q, out_idx_d;
  logic [WEIGHT_ADDR_W-1:0] wt_q, wt_d;
  logic [CW-1:0]          drn_q, drn_d;
  logic                   start_ok;
  logic                   accept;
  logic [1:0]             lat_q;

  assign layer_nx = layer_q + 1'b1;

  always_comb begin
    start_ok = int'(cfg_num_layers) >= 2 &&
               int'(cfg_num_layers) <= MAX_LAYERS;
    for (int i = 0; i < MAX_LAYERS; i++)
      if (i < int'(cfg_num_layers) && tbl_q[i] == '0)
        start_ok = 1'b0;
  end

  assign accept = (state_q == S_IDLE) && start && start_ok;

  always_comb begin
    state_d   = state_q;
    tbl_d     = tbl_q;
    nl_d      = nl_q;
    layer_d   = layer_q;
    in_idx_d  = in_idx_q;
    out_idx_d = out_idx_q;
    wt_d      = wt_q;
    drn_d     = drn_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (start_ok) begin
            state_d   = S_FETCH;
            nl_d      = cfg_num_layers;
            layer_d   = '0;
            in_idx_d  = '0;
            out_idx_d = '0;
            wt_d      = '0;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_FETCH: begin
        wt_d = wt_q + 1'b1;
        if (in_idx_q == tbl_q[layer_q] - 1'b1) begin
          in_idx_d = '0;
          drn_d    = '0;
          state_d  = S_DRAIN;
        end else begin
          in_idx_d = in_idx_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (int'(drn_q) == MEM_LAT - 1)
          state_d = S_WRITE;
        else
          drn_d = drn_q + 1'b1;
      end
      S_WRITE: begin
        state_d = S_FETCH;
        if (out_idx_q == tbl_q[layer_nx] - 1'b1) begin
          out_idx_d = '0;
          if (int'(layer_q) == int'(nl_q) - 2)
            state_d = S_DONE;
          else
            layer_d = layer_nx;
        end else begin
          out_idx_d = out_idx_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Table is frozen for the whole run, including the start cycle.
    if (cfg_we && !busy && !accept)
      tbl_d[cfg_layer] = cfg_count;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      nl_q      <= '0;
      layer_q   <= '0;
      in_idx_q  <= '0;
      out_idx_q <= '0;
      wt_q      <= '0;
      drn_q     <= '0;
      for (int i = 0; i < MAX_LAYERS; i++)
        tbl_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      nl_q      <= nl_d;
      layer_q   <= layer_d;
      in_idx_q  <= in_idx_d;
      out_idx_q <= out_idx_d;
      wt_q      <= wt_d;
      drn_q     <= drn_d;
      for (int i = 0; i < MAX_LAYERS; i++)
        tbl_q[i] <= tbl_d[i];
    end
  end

  assign busy  = state_q inside {S_FETCH, S_DRAIN, S_WRITE};
  assign rd_en = state_q == S_FETCH;
  assign wr_en = state_q == S_WRITE;
  assign done  = state_q == S_DONE;
  assign err   = state_q == S_ERR;

  assign wt_addr = wt_q;

  assign in_neuron_addr = rd_en ?
    AW'(neuron_addr(32'(layer_q), 32'(in_idx_q), NEURON_W)) : '0;

  assign out_neuron_addr = wr_en ?
    AW'(neuron_addr(32'(layer_nx), 32'(out_idx_q), NEURON_W)) : '0;

  mlp_lat_pipe #(
    .LAT (MEM_LAT),
    .W   (2)
  ) u_lat_pipe (
    .clk (clk),
    .rst (rst),
    .d   ({rd_en, rd_en && in_idx_q == '0}),
    .q   (lat_q)
  );

  assign acc_en  = lat_q[1];
  assign acc_clr = lat_q[0];
endmodule

// File: doc/mlp_sequencer.md
Name: mlp_sequencer

Overview:
- Programmable layer sequencer for the MLP multiply-accumulate datapath.
- Walks a runtime-loaded table of per-layer neuron counts and issues neuron/weight memory reads.
- Compensates memory read latency before driving the accumulator enables.
- Writes each finished neuron and reports completion through a start/busy/done/err handshake. Replaces the fixed-topology sequencing for networks of up to MAX_LAYERS layers.

Parameters:
- MAX_LAYERS, 8: table depth; layers including input and output.
- LAYER_W, 3: layer index width, log2(MAX_LAYERS).
- NEURON_W, 8: neuron count/index width; max 255 neurons per layer.
- WEIGHT_ADDR_W, 16: linear weight address width.
- MEM_LAT, 1: read latency of the neuron and weight memories in cycles, >=1.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- cfg_we, in, 1: write cfg_count into table[cfg_layer]; ignored while busy.
- cfg_layer, in, LAYER_W: table index.
- cfg_count, in, NEURON_W: neuron count for that layer.
- cfg_num_layers, in, LAYER_W+1: layers in the network; sampled at start.
- start, in, 1: start request; sampled only in IDLE.
- busy, out, 1: high FETCH through WRITE.
- done, out, 1: 1-cycle pulse after the final neuron write.
- err, out, 1: 1-cycle pulse when a start is rejected.
- rd_en, out, 1: read strobe for neuron and weight memories.
- in_neuron_addr, out, LAYER_W+NEURON_W: {layer, input index}.
- wt_addr, out, WEIGHT_ADDR_W: linear weight address.
- acc_en, out, 1: accumulate the product of the returned data.
- acc_clr, out, 1: with acc_en, load the product instead of adding it (first term of a neuron).
- wr_en, out, 1: write accumulator to out_neuron_addr.
- out_neuron_addr, out, LAYER_W+NEURON_W: {layer+1, output index}.

Behaviour:
- Reset (async): all outputs 0; table entries 0; all pointers 0; wt_addr 0; FSM in IDLE. A reset mid-run aborts immediately and produces no done pulse.
- States:
  - IDLE --start--> FETCH, or ERR.
  - FETCH --last input of neuron issued--> DRAIN.
  - DRAIN --MEM_LAT cycles--> WRITE.
  - WRITE --> FETCH (more neurons) or DONE.
  - DONE --> IDLE.
  - ERR --> IDLE.
- Start validation:
  - Start is accepted when num_layers is in 2..MAX_LAYERS and every table[0..num_layers-1] is nonzero. An accepted start latches num_layers, and sets layer=0, out_idx=0, in_idx=0, wt_addr=0.
  - Otherwise the FSM enters ERR: err pulses 1 cycle and nothing else changes.
  - Start while busy is ignored.
- FETCH:
  - rd_en=1 each cycle, with in_neuron_addr={layer,in_idx} and wt_addr driven combinationally from the current pointers.
  - in_idx increments and wt_addr increments by 1 per read.
  - On in_idx==table[layer]-1 the FSM moves to DRAIN and in_idx returns to 0.
- Latency pipe:
  - A MEM_LAT-deep shift register carries {valid, first}.
  - acc_en is rd_en delayed MEM_LAT cycles.
  - acc_clr is high with the delayed first read of each neuron.
- WRITE:
  - wr_en=1 for 1 cycle with out_neuron_addr={layer+1,out_idx}. This is the cycle after the last acc_en.
  - If out_idx==table[layer+1]-1: if layer==num_layers-2, go to DONE; else layer++ and out_idx=0.
  - Otherwise out_idx++.
- Timing per neuron:
  - N=table[layer] reads, MEM_LAT drain cycles, 1 write: N+MEM_LAT+1 cycles.
  - Neurons do not overlap.
  - First rd_en is in the cycle after start is sampled.
- DONE: done=1 and busy=0 in the same cycle; the FSM returns to IDLE next cycle.
- wt_addr wraps modulo 2^WEIGHT_ADDR_W. No error is raised; sizing is the user's responsibility.
- Config writes while busy are dropped; the running table is never modified mid-run. A cfg_we coincident with an accepted start is dropped.

Decomposition:
- Shared package mlp_pkg holds:
  - the state enum;
  - the layer/neuron index typedefs;
  - the address concatenation helper function;
  - default widths.
- Sub-module mlp_lat_pipe: parameterised MEM_LAT shift register for {valid, first}, reused by the softmax reader.

Test Plan:
1. Table 4,2,2,1, num_layers=4, MEM_LAT=1, start pulse:
   - 14 rd_en cycles with wt_addr 0..13.
   - wr_en to addrs {1,0},{1,1},{2,0},{2,1},{3,0} at cycles 5,11,15,19,23 counted from first rd_en (cycle 0).
   - done at cycle 24.
2. Same network with MEM_LAT=3:
   - acc_en trails rd_en by exactly 3 cycles.
   - acc_clr high on the first acc_en of each of the 5 neurons.
   - done at cycle 34.
3. num_layers=1, or table[2]=0 with num_layers=4: err pulses 1 cycle; busy, rd_en and wr_en stay 0.
4. Start and cfg_we asserted during cycle 7 of scenario 1: both are ignored; the result is identical to scenario 1; a subsequent start after done reruns with wt_addr starting at 0.
5. rst asserted asynchronously at cycle 9 of scenario 1: all outputs 0 without waiting for a clock edge; table reads back 0 (a start then gives err); no done pulse.
6. Table 255,255,1, num_layers=3, WEIGHT_ADDR_W=16: 255*256 = 65280 reads, wt_addr ending at 65279; 256 writes; done asserted.
